// File: rtl/present_pkg.sv
// present_pkg: shared PRESENT-80 definitions for the encrypt and decrypt cores.
//   - KEY_W / BLK_W / ROUNDS_STD width and round-count constants
//   - SBOX / INV_SBOX nibble tables (nibble n of the constant holds S[n])
//   - s_layer / inv_s_layer, p_layer / inv_p_layer block permutations
//   - key_update / inv_key_update one-step key schedule (key, 5-bit round counter)
package present_pkg;

  localparam int unsigned KEY_W      = 80;
  localparam int unsigned BLK_W      = 64;
  localparam int unsigned ROUNDS_STD = 31;

  localparam logic [63:0] SBOX     = 64'h21748FE3DA09B65C;
  localparam logic [63:0] INV_SBOX = 64'hA970364BD21C8FE5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_KEYEXP,
    ST_DEC,
    ST_FINAL
  } dec_state_t;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    return INV_SBOX[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [BLK_W-1:0] s_layer(input logic [BLK_W-1:0] b);
    logic [BLK_W-1:0] r;
    logic [5:0]       base;
    r = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      base = {i[3:0], 2'b00};
      r[base +: 4] = sbox(b[base +: 4]);
    end
    return r;
  endfunction

  function automatic logic [BLK_W-1:0] inv_s_layer(input logic [BLK_W-1:0] b);
    logic [BLK_W-1:0] r;
    logic [5:0]       base;
    r = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      base = {i[3:0], 2'b00};
      r[base +: 4] = inv_sbox(b[base +: 4]);
    end
    return r;
  endfunction

  // Forward pLayer: bit i -> bit 16*i mod 63, bit 63 fixed.
  function automatic logic [BLK_W-1:0] p_layer(input logic [BLK_W-1:0] b);
    logic [BLK_W-1:0] r;
    logic [5:0]       j;
    r = '0;
    for (int unsigned i = 0; i < 63; i++) begin
      j    = 6'((i * 16) % 63);
      r[j] = b[i[5:0]];
    end
    r[63] = b[63];
    return r;
  endfunction

  // Inverse pLayer: since 16*4 = 64 = 1 (mod 63), undoing the forward
  // permutation moves bit i to bit 4*i mod 63.
  function automatic logic [BLK_W-1:0] inv_p_layer(input logic [BLK_W-1:0] b);
    logic [BLK_W-1:0] r;
    logic [5:0]       j;
    r = '0;
    for (int unsigned i = 0; i < 63; i++) begin
      j    = 6'((i * 4) % 63);
      r[j] = b[i[5:0]];
    end
    r[63] = b[63];
    return r;
  endfunction

  function automatic logic [KEY_W-1:0] key_update(input logic [KEY_W-1:0] k,
                                                   input logic [4:0]       cnt);
    logic [KEY_W-1:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = sbox(r[79:76]);
    r[19:15]   = r[19:15] ^ cnt;
    return r;
  endfunction

  // Exact inverse of key_update: undo the counter XOR, then the S-box, then
  // rotate back the 19 positions the forward step moved the register.
  function automatic logic [KEY_W-1:0] inv_key_update(input logic [KEY_W-1:0] k,
                                                       input logic [4:0]       cnt);
    logic [KEY_W-1:0] r;
    r          = k;
    r[19:15]   = r[19:15] ^ cnt;
    r[79:76]   = inv_sbox(r[79:76]);
    return {r[60:0], r[79:61]};
  endfunction

endpackage

// File: rtl/present_key_step.sv
// present_key_step: single combinational key-schedule step, shared by the
// forward expansion and the inverse walk-back so only one path exists.
//   key_in  [79:0] current key register
//   cnt     [4:0]  round counter mixed into bits [19:15]
//   dir            0 = forward update, 1 = inverse update
//   key_out [79:0] updated key register
module present_key_step
  import present_pkg::*;
(
  input  logic [KEY_W-1:0] key_in,
  input  logic [4:0]       cnt,
  input  logic             dir,
  output logic [KEY_W-1:0] key_out
);

  always_comb begin
    key_out = dir ? inv_key_update(key_in, cnt) : key_update(key_in, cnt);
  end

endmodule

// File: rtl/present_decrypt.sv
// present_decrypt: iterative PRESENT-80 decryption, one round per clock.
// The key is first run forward to the last round key, then walked back one
// step per inverse round, so no round keys are stored.
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   start       request pulse, sampled only in IDLE
//   ciphertext  [63:0] input block, latched on accept
//   key         [79:0] user key, latched on accept
//   plaintext   [63:0] registered result, held until the next accept
//   busy        high from the accept edge through the final edge
//   ready       high once plaintext is valid, until the next accept
module present_decrypt
  import present_pkg::*;
#(
  parameter int unsigned ROUNDS = ROUNDS_STD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BLK_W-1:0] ciphertext,
  input  logic [KEY_W-1:0] key,
  output logic [BLK_W-1:0] plaintext,
  output logic             busy,
  output logic             ready
);

  localparam logic [4:0] LAST_CNT = 5'(ROUNDS);

  dec_state_t       fsm, fsm_nxt;
  logic [BLK_W-1:0] state_reg, state_nxt;
  logic [KEY_W-1:0] key_reg, key_nxt;
  logic [4:0]       cnt, cnt_nxt;
  logic [BLK_W-1:0] plaintext_nxt;
  logic             busy_nxt, ready_nxt;
  logic             key_dir;
  logic [KEY_W-1:0] key_step_out;
  logic [BLK_W-1:0] round_key;

  present_key_step u_key_step (
    .key_in  (key_reg),
    .cnt     (cnt),
    .dir     (key_dir),
    .key_out (key_step_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm       <= ST_IDLE;
      state_reg <= '0;
      key_reg   <= '0;
      cnt       <= '0;
      plaintext <= '0;
      busy      <= 1'b0;
      ready     <= 1'b0;
    end else begin
      fsm       <= fsm_nxt;
      state_reg <= state_nxt;
      key_reg   <= key_nxt;
      cnt       <= cnt_nxt;
      plaintext <= plaintext_nxt;
      busy      <= busy_nxt;
      ready     <= ready_nxt;
    end
  end

  always_comb begin
    fsm_nxt       = fsm;
    state_nxt     = state_reg;
    key_nxt       = key_reg;
    cnt_nxt       = cnt;
    plaintext_nxt = plaintext;
    busy_nxt      = busy;
    ready_nxt     = ready;
    key_dir       = (fsm == ST_DEC);
    round_key     = key_reg[KEY_W-1 -: BLK_W];

    case (fsm)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ciphertext;
          key_nxt   = key;
          cnt_nxt   = 5'd1;
          busy_nxt  = 1'b1;
          ready_nxt = 1'b0;
          fsm_nxt   = ST_KEYEXP;
        end
      end
      ST_KEYEXP: begin
        key_nxt = key_step_out;
        if (cnt == LAST_CNT) begin
          fsm_nxt = ST_DEC;
        end else begin
          cnt_nxt = cnt + 5'd1;
        end
      end
      ST_DEC: begin
        state_nxt = inv_s_layer(inv_p_layer(state_reg ^ round_key));
        key_nxt   = key_step_out;
        cnt_nxt   = cnt - 5'd1;
        if (cnt == 5'd1) begin
          fsm_nxt = ST_FINAL;
        end
      end
      ST_FINAL: begin
        plaintext_nxt = state_reg ^ round_key;
        ready_nxt     = 1'b1;
        busy_nxt      = 1'b0;
        fsm_nxt       = ST_IDLE;
      end
      default: begin
        fsm_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_present_decrypt.sv
// tb_present_decrypt: scoreboard bench for present_decrypt. Expected plaintext
// and the cycle at which ready must rise are queued when a request is issued;
// a monitor pops and compares whenever ready rises.
module tb_present_decrypt;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [63:0] ciphertext = '0;
  logic [79:0] key = '0;
  logic [63:0] plaintext;
  logic        busy;
  logic        ready;

  present_decrypt #(.ROUNDS(31)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ciphertext (ciphertext),
    .key        (key),
    .plaintext  (plaintext),
    .busy       (busy),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] pt;
    int unsigned cyc;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_vec = 0;
  int unsigned n_fail = 0;
  logic        b2b_mode = 1'b0;

  localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                     4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  // Reference PRESENT-80 encryption written straight from the algorithm.
  function automatic logic [63:0] ref_encrypt(input logic [63:0] pt, input logic [79:0] k);
    logic [79:0] kr;
    logic [63:0] s, t;
    kr = k;
    s  = pt;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ kr[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = SB[s[4*n +: 4]];
      t = '0;
      for (int b = 0; b < 64; b++) t[(b == 63) ? 63 : (b * 16) % 63] = s[b];
      s = t;
      kr = {kr[18:0], kr[79:19]};
      kr[79:76] = SB[kr[79:76]];
      kr[19:15] = kr[19:15] ^ 5'(r);
    end
    return s ^ kr[79:16];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare on every rising edge of ready.
  logic ready_prev = 1'b0;
  logic pulse_chk = 1'b0;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (pulse_chk) begin
      pulse_chk = 1'b0;
      chk("ready_pulse_low", {63'd0, ready}, 64'd0);
      chk("busy_after_b2b_accept", {63'd0, busy}, 64'd1);
    end
    if (ready === 1'b1 && ready_prev !== 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_ready: got result %h, expected no result (cycle %0d)",
                 plaintext, cyc);
      end else begin
        e = sb_q.pop_front();
        chk("plaintext", plaintext, e.pt);
        chk("ready_latency", 64'(cyc), 64'(e.cyc));
        chk("busy_at_ready", {63'd0, busy}, 64'd0);
        if (b2b_mode) pulse_chk = 1'b1;
      end
    end
    ready_prev = ready;
  end

  task automatic issue(input logic [63:0] ct, input logic [79:0] k, input logic [63:0] pt);
    exp_t e;
    @(negedge clk);
    start      = 1'b1;
    ciphertext = ct;
    key        = k;
    e.pt  = pt;
    e.cyc = cyc + 64;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", {63'd0, busy}, 64'd1);
    chk("ready_after_accept", {63'd0, ready}, 64'd0);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d results pending, expected 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  function automatic logic [79:0] rand_key();
    return {16'($urandom), $urandom, $urandom};
  endfunction

  function automatic logic [63:0] rand_blk();
    return {$urandom, $urandom};
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no completion, expected $finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] pt;
    logic [79:0] k;
    exp_t        e;

    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_plaintext", plaintext, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_ready", {63'd0, ready}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Known-answer vectors.
    issue(64'h5579C1387B228445, 80'h0, 64'h0);
    wait_done("kat_zero");

    // Second start and input changes at E20 must not disturb the run.
    issue(64'h5579C1387B228445, 80'h0, 64'h0);
    repeat (19) @(negedge clk);
    start      = 1'b1;
    ciphertext = rand_blk();
    key        = rand_key();
    @(negedge clk);
    chk("busy_mid_run", {63'd0, busy}, 64'd1);
    start      = 1'b0;
    ciphertext = rand_blk();
    key        = rand_key();
    wait_done("restart_ignored");
    repeat (5) @(negedge clk);

    issue(64'hE72C46C0F5945049, {80{1'b1}}, 64'h0);
    wait_done("kat_ones_key");
    issue(64'hA112FFC72F68417B, 80'h0, {64{1'b1}});
    wait_done("kat_ones_pt");
    issue(64'h3333DCD3213210D2, {80{1'b1}}, {64{1'b1}});
    wait_done("kat_ones_both");

    // Abort at E40 by reset; outputs clear immediately.
    pt = rand_blk();
    k  = rand_key();
    issue(ref_encrypt(pt, k), k, pt);
    repeat (40) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_plaintext", plaintext, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_ready", {63'd0, ready}, 64'd0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    pt = rand_blk();
    k  = rand_key();
    issue(ref_encrypt(pt, k), k, pt);
    wait_done("after_abort");

    // Back-to-back loopback with start held high: one accept every 64 cycles.
    b2b_mode = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int v = 0; v < 1000; v++) begin
      pt = rand_blk();
      k  = rand_key();
      ciphertext = ref_encrypt(pt, k);
      key        = k;
      e.pt  = pt;
      e.cyc = cyc + 64;
      sb_q.push_back(e);
      if (v < 999) begin
        repeat (64) @(negedge clk);
      end else begin
        @(negedge clk);
        start    = 1'b0;
        b2b_mode = 1'b0;
      end
    end
    wait_done("loopback");
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
